spn_round_controller: RTL

SPN_ROUND_CONTROLLER -- requirements
Module: spn_round_controller

---
 rtl/spn_round_controller_pkg.sv | 16 +
 rtl/spn_round_controller_key_scheduler.sv | 22 ++
 rtl/spn_round_controller.sv | 111 +++++++++++
 3 files changed

// File: rtl/spn_round_controller_pkg.sv
// Shared types and sizing for the SPN round controller and its key scheduler.
package spn_round_controller_pkg;

    localparam int NUM_ROUNDS = 3;
    localparam int BLOCK_W    = 16;
    localparam int KEY_W      = 32;
    localparam int ROUND_W    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } spn_ctrl_state_t;

endpackage

// File: rtl/spn_round_controller_key_scheduler.sv
// Combinational round-key derivation; decrypt walks the outer keys in reverse order.
module key_scheduler
    import spn_round_controller_pkg::*;
(
    input  logic [KEY_W-1:0]   i_key,
    input  logic               i_mode,
    output logic [BLOCK_W-1:0] o_key0,
    output logic [BLOCK_W-1:0] o_key1,
    output logic [BLOCK_W-1:0] o_key2
);

    logic [BLOCK_W-1:0] w_key_hi;
    logic [BLOCK_W-1:0] w_key_mid;

    assign w_key_hi  = {i_key[7:0], i_key[31:24]};
    assign w_key_mid = {i_key[7:0], i_key[23:16]};

    assign o_key0 = i_mode ? w_key_hi  : w_key_mid;
    assign o_key1 = i_key[15:0];
    assign o_key2 = i_mode ? w_key_mid : w_key_hi;

endmodule

// File: rtl/spn_round_controller.sv
// Sequences three rounds of an external SPN datapath over one captured block/key/mode.
module spn_round_controller
    import spn_round_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_block,
    input  logic [31:0] in_key,
    input  logic        in_mode,
    input  logic        abort,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_block,
    output logic        rd_start,
    output logic [15:0] rd_state,
    output logic [15:0] rd_key,
    output logic [1:0]  rd_round,
    output logic        rd_last,
    output logic        rd_mode,
    input  logic        rd_done,
    input  logic [15:0] rd_result,
    output logic        busy
);

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

    spn_ctrl_state_t      r_state;
    logic [BLOCK_W-1:0]   r_block;
    logic [KEY_W-1:0]     r_key;
    logic                 r_mode;
    logic [ROUND_W-1:0]   r_round;

    logic [BLOCK_W-1:0]   w_key0;
    logic [BLOCK_W-1:0]   w_key1;
    logic [BLOCK_W-1:0]   w_key2;
    logic [BLOCK_W-1:0]   w_rd_key;

    // abort outranks every other event, including rd_done and out_ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_block <= '0;
            r_key   <= '0;
            r_mode  <= 1'b0;
            r_round <= '0;
        end else if (abort) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_block <= in_block;
                        r_key   <= in_key;
                        r_mode  <= in_mode;
                        r_round <= '0;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: r_state <= WAIT;
                WAIT: begin
                    if (rd_done) begin
                        r_block <= rd_result;
                        if (r_round < LAST_ROUND) begin
                            r_round <= r_round + ROUND_W'(1);
                            r_state <= ISSUE;
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    key_scheduler u_key_scheduler (
        .i_key  (r_key),
        .i_mode (r_mode),
        .o_key0 (w_key0),
        .o_key1 (w_key1),
        .o_key2 (w_key2)
    );

    always_comb begin
        w_rd_key = w_key0;
        case (r_round)
            2'd1:    w_rd_key = w_key1;
            2'd2:    w_rd_key = w_key2;
            default: w_rd_key = w_key0;
        endcase
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DONE);
    assign out_block = r_block;
    assign rd_start  = (r_state == ISSUE) && !abort;
    assign rd_state  = r_block;
    assign rd_key    = w_rd_key;
    assign rd_round  = r_round;
    assign rd_last   = (r_round == LAST_ROUND);
    assign rd_mode   = r_mode;

endmodule
